seq_window_checker: RTL and testbench
=====================================

Name: seq_window_checker

Overview:
- Synthesizable, multi-channel, parametrised checker for "valid |-> a ##[MIN_DLY:MAX_DLY] b". It replaces the single-channel, fixed-delay simulation-only assertion.
- Each channel independently tracks overlapping attempts. It reports per-attempt pass/fail pulses, sticky error flags and saturating pass/fail counters.
- Sits beside protocol datapaths as an on-chip monitor; the counters are readable by status logic.

Parameters:
- NUM_CH, 4, number of independent channels (1..32)
- MIN_DLY, 3, earliest cycle after the start at which b satisfies the attempt (1 <= MIN_DLY <= MAX_DLY)
- MAX_DLY, 3, latest cycle after the start at which b satisfies the attempt (MAX_DLY <= 32)
- CNT_W, 16, width of each per-channel counter (>= 2)

Ports:
- clk  in  1  clock; all sampling on posedge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  global enable for new attempts
- clr  in  1  synchronous clear of pending attempts, counters and sticky flags
- valid  in  NUM_CH  per-channel antecedent
- a  in  NUM_CH  per-channel first consequent term
- b  in  NUM_CH  per-channel delayed consequent term
- pass_o  out  NUM_CH  one-cycle pulse: at least one attempt passed
- fail_o  out  NUM_CH  one-cycle pulse: at least one attempt failed
- err_sticky  out  NUM_CH  set on any fail; held until clr or reset
- busy  out  NUM_CH  channel has at least one pending attempt
- pass_cnt  out  NUM_CH*CNT_W  packed per-channel pass counts; ch i at [i*CNT_W +: CNT_W]
- fail_cnt  out  NUM_CH*CNT_W  packed per-channel fail counts, same packing

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0): all outputs are 0, all counters are 0, and all pending attempts are discarded immediately. No pass or fail is reported for discarded attempts.
- Per channel, the pending state is a vector pend[1..MAX_DLY]. pend[k]=1 means an attempt started k edges ago and is unresolved.
- At edge E0 with en=1 and valid=1:
  - a=1: the attempt starts; pend[1] is set after E0.
  - a=0: immediate fail decided at E0.
- With en=0, no new attempts or immediate fails occur. In-flight attempts continue to resolve.
- At each edge, for every pending age k:
  - k >= MIN_DLY and b=1: the attempt passes and is cleared.
  - k = MAX_DLY and b=0: the attempt fails (timeout) and is cleared.
  - Otherwise the attempt advances to age k+1.
- One b pulse satisfies every pending attempt whose window covers that edge.
- Outputs are registered. A decision made at edge Ek is visible from Ek until E(k+1): pass_o and fail_o are high for exactly one cycle.
- pass_o and fail_o may both be high in the same cycle when different attempts resolve.
- Counter increments per cycle:
  - pass_cnt: popcount of attempts passing at that edge (up to MAX_DLY-MIN_DLY+1).
  - fail_cnt: timeout (0/1) plus immediate fail (0/1), so at most 2 per cycle.
- Counters saturate at all-ones and never wrap. An increment that would exceed the maximum clamps to all-ones.
- err_sticky[i] is set in the same cycle fail_o[i] asserts.
- busy[i] is the registered OR of pend[i].
- clr=1 at an edge:
  - flushes pend, zeroes the counters and err_sticky, and forces pass_o and fail_o to 0 the following cycle;
  - takes priority over any start, pass or fail evaluated at that edge;
  - attempts flushed by clr produce no report.
- Channels are fully independent. No cross-channel interaction.
- With MIN_DLY=MAX_DLY=3, the block reproduces the "valid |-> a ##3 b" check exactly, per channel.

Test Plan:
- Defaults: ch0 valid=a=1 at E0 only, b=1 at E3 -> pass_o[0]=1 for cycle E3..E4; pass_cnt[0]=1; fail_cnt[0]=0; busy[0]=1 from E0 to E3.
- Defaults: ch1 valid=1, a=0 at E0 -> fail_o[1]=1 for cycle E0..E1; err_sticky[1]=1 stays set; fail_cnt[1]=1; other channels untouched.
- Defaults: ch2 start at E0, b=0 at E1..E3, b=1 at E4 -> fail_o[2] after E3; no pass at E4; fail_cnt[2]=1.
- MIN_DLY=2, MAX_DLY=4:
  - ch0 starts at E0 and E1, single b=1 at E3 -> both pass at E3; pass_cnt[0]=2.
  - ch0 start at E5, b=0 through E9, plus valid=1/a=0 at E9 -> fail_cnt[0] += 2 in one cycle.
- CNT_W=2: seven immediate fails on ch3 -> fail_cnt[3]=3 (saturated); then clr=1 -> 0 and err_sticky[3]=0 next cycle.
- Defaults: start on ch0 at E0; rst_n low between E1 and E2, released before E3; b=1 at E3 -> no pass_o/fail_o; counters 0; busy 0. Repeat with clr at E2 instead of reset -> same result.

Source files
------------

// File: rtl/seq_window_checker.sv
// Multi-channel on-chip checker for "valid |-> a ##[MIN_DLY:MAX_DLY] b".
// Each channel tracks overlapping attempts in an age-indexed pending vector.
module seq_window_checker #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MIN_DLY = 3,
    parameter int unsigned MAX_DLY = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic [NUM_CH-1:0]         valid,
    input  logic [NUM_CH-1:0]         a,
    input  logic [NUM_CH-1:0]         b,
    output logic [NUM_CH-1:0]         pass_o,
    output logic [NUM_CH-1:0]         fail_o,
    output logic [NUM_CH-1:0]         err_sticky,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH*CNT_W-1:0]   pass_cnt,
    output logic [NUM_CH*CNT_W-1:0]   fail_cnt
);

    // Increment width covers up to 32 simultaneous passes.
    localparam int unsigned PW = 6;
    localparam int unsigned SW = CNT_W + PW;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [PW-1:0]    inc);
        logic [SW-1:0] sum;
        sum = {{PW{1'b0}}, cnt} + {{CNT_W{1'b0}}, inc};
        if (sum > {{PW{1'b0}}, {CNT_W{1'b1}}}) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [MAX_DLY:1] pend_q, pend_d;
        logic [MAX_DLY:1] hit;
        logic             start, imm_fail, timeout;
        logic [PW-1:0]    pass_inc;
        logic [PW-1:0]    fail_inc;
        logic             pass_d, fail_d;
        logic             pass_q, fail_q, err_q, busy_q;
        logic [CNT_W-1:0] pcnt_q, fcnt_q, pcnt_d, fcnt_d;

        always_comb begin
            start    = en & valid[ch] & a[ch];
            imm_fail = en & valid[ch] & ~a[ch];
            timeout  = pend_q[MAX_DLY] & ~b[ch];

            hit      = '0;
            pass_inc = '0;
            for (int unsigned k = MIN_DLY; k <= MAX_DLY; k++) begin
                hit[k]   = pend_q[k] & b[ch];
                pass_inc = pass_inc + PW'(hit[k]);
            end

            // Age MAX_DLY always resolves (pass or timeout), so it never shifts on.
            pend_d    = '0;
            pend_d[1] = start;
            for (int unsigned k = 1; k < MAX_DLY; k++) begin
                pend_d[k+1] = pend_q[k] & ~hit[k];
            end

            fail_inc = PW'(timeout) + PW'(imm_fail);
            pass_d   = |hit;
            fail_d   = timeout | imm_fail;
            pcnt_d   = sat_add(pcnt_q, pass_inc);
            fcnt_d   = sat_add(fcnt_q, fail_inc);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q <= '0;
                pass_q <= 1'b0;
                fail_q <= 1'b0;
                err_q  <= 1'b0;
                busy_q <= 1'b0;
                pcnt_q <= '0;
                fcnt_q <= '0;
            end else if (clr) begin
                pend_q <= '0;
                pass_q <= 1'b0;
                fail_q <= 1'b0;
                err_q  <= 1'b0;
                busy_q <= 1'b0;
                pcnt_q <= '0;
                fcnt_q <= '0;
            end else begin
                pend_q <= pend_d;
                pass_q <= pass_d;
                fail_q <= fail_d;
                err_q  <= err_q | fail_d;
                busy_q <= |pend_d;
                pcnt_q <= pcnt_d;
                fcnt_q <= fcnt_d;
            end
        end

        assign pass_o[ch]                    = pass_q;
        assign fail_o[ch]                    = fail_q;
        assign err_sticky[ch]                = err_q;
        assign busy[ch]                      = busy_q;
        assign pass_cnt[ch*CNT_W +: CNT_W]   = pcnt_q;
        assign fail_cnt[ch*CNT_W +: CNT_W]   = fcnt_q;
    end

endmodule

// File: tb/tb_seq_window_checker.sv
// Scoreboard bench: three configurations of seq_window_checker against an
// attempt-list reference model (defaults, MIN=2/MAX=4, CNT_W=2).
module tb_seq_window_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en_s  [3];
    logic       clr_s [3];
    logic [3:0] vld_s [3];
    logic [3:0] a_s   [3];
    logic [3:0] b_s   [3];

    logic [3:0]  po0, fo0, es0, bz0, po1, fo1, es1, bz1, po2, fo2, es2, bz2;
    logic [63:0] pc0, fc0, pc1, fc1;
    logic [7:0]  pc2, fc2;

    seq_window_checker dut0 (
        .clk(clk), .rst_n(rst_n), .en(en_s[0]), .clr(clr_s[0]),
        .valid(vld_s[0]), .a(a_s[0]), .b(b_s[0]),
        .pass_o(po0), .fail_o(fo0), .err_sticky(es0), .busy(bz0),
        .pass_cnt(pc0), .fail_cnt(fc0));

    seq_window_checker #(.MIN_DLY(2), .MAX_DLY(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en_s[1]), .clr(clr_s[1]),
        .valid(vld_s[1]), .a(a_s[1]), .b(b_s[1]),
        .pass_o(po1), .fail_o(fo1), .err_sticky(es1), .busy(bz1),
        .pass_cnt(pc1), .fail_cnt(fc1));

    seq_window_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en_s[2]), .clr(clr_s[2]),
        .valid(vld_s[2]), .a(a_s[2]), .b(b_s[2]),
        .pass_o(po2), .fail_o(fo2), .err_sticky(es2), .busy(bz2),
        .pass_cnt(pc2), .fail_cnt(fc2));

    typedef struct { int cfg; int ch; int t0; } att_t;
    typedef struct { int cfg; int ch; bit p; bit f; bit e; bit bz; int pc; int fc; } exp_t;

    att_t att_q[$];
    exp_t exp_q[$];

    int mn   [3] = '{3, 2, 3};
    int mx   [3] = '{3, 4, 3};
    int cmax [3] = '{65535, 65535, 3};
    int m_pc [3][4];
    int m_fc [3][4];
    bit m_err[3][4];
    int t = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic obs(input int cfg, input int ch, output logic p, output logic f,
                       output logic e, output logic bz, output logic [31:0] pc,
                       output logic [31:0] fc);
        case (cfg)
            0: begin p = po0[ch]; f = fo0[ch]; e = es0[ch]; bz = bz0[ch];
                     pc = 32'(pc0[ch*16 +: 16]); fc = 32'(fc0[ch*16 +: 16]); end
            1: begin p = po1[ch]; f = fo1[ch]; e = es1[ch]; bz = bz1[ch];
                     pc = 32'(pc1[ch*16 +: 16]); fc = 32'(fc1[ch*16 +: 16]); end
            default: begin p = po2[ch]; f = fo2[ch]; e = es2[ch]; bz = bz2[ch];
                     pc = 32'(pc2[ch*2 +: 2]); fc = 32'(fc2[ch*2 +: 2]); end
        endcase
    endtask

    task automatic model_reset();
        att_q.delete();
        for (int c = 0; c < 3; c++)
            for (int ch = 0; ch < 4; ch++) begin
                m_pc[c][ch] = 0; m_fc[c][ch] = 0; m_err[c][ch] = 0;
            end
    endtask

    // Predict the outputs that the coming edge produces for configuration cfg.
    task automatic model_edge(input int cfg, input bit e, input bit c,
                              input bit [3:0] v, input bit [3:0] aa, input bit [3:0] bb);
        att_t nq[$];
        att_t at;
        exp_t ex;
        int   ip[4], ifl[4];
        bit   pe[4], fe[4];
        for (int ch = 0; ch < 4; ch++) begin ip[ch] = 0; ifl[ch] = 0; pe[ch] = 0; fe[ch] = 0; end
        if (!rst_n || c) begin
            foreach (att_q[i]) if (att_q[i].cfg != cfg) nq.push_back(att_q[i]);
            att_q = nq;
            for (int ch = 0; ch < 4; ch++) begin
                m_pc[cfg][ch] = 0; m_fc[cfg][ch] = 0; m_err[cfg][ch] = 0;
                ex = '{cfg, ch, 0, 0, 0, 0, 0, 0};
                exp_q.push_back(ex);
            end
            return;
        end
        foreach (att_q[i]) begin
            at = att_q[i];
            if (at.cfg != cfg) nq.push_back(at);
            else if ((t - at.t0) >= mn[cfg] && bb[at.ch]) begin pe[at.ch] = 1; ip[at.ch]++; end
            else if ((t - at.t0) == mx[cfg]) begin fe[at.ch] = 1; ifl[at.ch]++; end
            else nq.push_back(at);
        end
        for (int ch = 0; ch < 4; ch++) begin
            if (e && v[ch]) begin
                if (aa[ch]) begin at = '{cfg, ch, t}; nq.push_back(at); end
                else begin fe[ch] = 1; ifl[ch]++; end
            end
        end
        att_q = nq;
        for (int ch = 0; ch < 4; ch++) begin
            m_pc[cfg][ch] = (m_pc[cfg][ch] + ip[ch] > cmax[cfg]) ? cmax[cfg] : m_pc[cfg][ch] + ip[ch];
            m_fc[cfg][ch] = (m_fc[cfg][ch] + ifl[ch] > cmax[cfg]) ? cmax[cfg] : m_fc[cfg][ch] + ifl[ch];
            m_err[cfg][ch] = m_err[cfg][ch] | fe[ch];
            ex = '{cfg, ch, pe[ch], fe[ch], m_err[cfg][ch], 0, m_pc[cfg][ch], m_fc[cfg][ch]};
            foreach (att_q[i]) if (att_q[i].cfg == cfg && att_q[i].ch == ch) ex.bz = 1;
            exp_q.push_back(ex);
        end
    endtask

    task automatic step(input int cfg, input bit e, input bit c,
                        input bit [3:0] v, input bit [3:0] aa, input bit [3:0] bb);
        exp_t ex;
        logic p, f, er, bz;
        logic [31:0] pc, fc;
        for (int i = 0; i < 3; i++) begin
            en_s[i] = 0; clr_s[i] = 0; vld_s[i] = '0; a_s[i] = '0; b_s[i] = '0;
        end
        en_s[cfg] = e; clr_s[cfg] = c; vld_s[cfg] = v; a_s[cfg] = aa; b_s[cfg] = bb;
        model_edge(cfg, e, c, v, aa, bb);
        @(posedge clk);
        #1;
        t++;
        for (int ch = 0; ch < 4; ch++) begin
            ex = exp_q.pop_front();
            obs(ex.cfg, ex.ch, p, f, er, bz, pc, fc);
            chk($sformatf("t%0d c%0d ch%0d pass_o", t, cfg, ch), 32'(p), 32'(ex.p));
            chk($sformatf("t%0d c%0d ch%0d fail_o", t, cfg, ch), 32'(f), 32'(ex.f));
            chk($sformatf("t%0d c%0d ch%0d err_sticky", t, cfg, ch), 32'(er), 32'(ex.e));
            chk($sformatf("t%0d c%0d ch%0d busy", t, cfg, ch), 32'(bz), 32'(ex.bz));
            chk($sformatf("t%0d c%0d ch%0d pass_cnt", t, cfg, ch), pc, ex.pc);
            chk($sformatf("t%0d c%0d ch%0d fail_cnt", t, cfg, ch), fc, ex.fc);
        end
    endtask

    task automatic idle(input int cfg, input int n);
        for (int i = 0; i < n; i++) step(cfg, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic random_phase(input int cfg, input int n);
        for (int i = 0; i < n; i++)
            step(cfg, $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0,
                 4'($urandom), 4'($urandom | $urandom), 4'($urandom));
        idle(cfg, 6);
    endtask

    initial begin
        logic p, f, er, bz;
        logic [31:0] pc, fc;
        for (int i = 0; i < 3; i++) begin
            en_s[i] = 0; clr_s[i] = 0; vld_s[i] = '0; a_s[i] = '0; b_s[i] = '0;
        end
        model_reset();
        step(0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        step(0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;

        // Defaults: single pass, immediate fail, timeout.
        step(0, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        idle(0, 2);
        step(0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001);
        idle(0, 2);
        step(0, 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0000);
        idle(0, 2);
        step(0, 1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0000);
        idle(0, 3);
        step(0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0100);
        idle(0, 2);
        // en=0 blocks starts and immediate fails.
        step(0, 1'b0, 1'b0, 4'b1111, 4'b0101, 4'b0000);
        idle(0, 4);

        // MIN=2 MAX=4: one b satisfies two overlapping attempts; double fail.
        step(1, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        step(1, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        idle(1, 1);
        step(1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001);
        idle(1, 1);
        step(1, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        idle(1, 3);
        step(1, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        idle(1, 2);

        // CNT_W=2: saturation of fail_cnt, then clear.
        for (int i = 0; i < 7; i++) step(2, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b0000);
        step(2, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        idle(2, 1);

        // Asynchronous reset discards an in-flight attempt.
        step(0, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        idle(0, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            obs(0, ch, p, f, er, bz, pc, fc);
            chk($sformatf("async_rst ch%0d busy", ch), 32'(bz), 32'd0);
            chk($sformatf("async_rst ch%0d cnt", ch), pc | fc, 32'd0);
            chk($sformatf("async_rst ch%0d flags", ch), 32'({p, f, er}), 32'd0);
        end
        step(0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        step(0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001);
        idle(0, 2);

        // Same with clr at E2.
        step(0, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        idle(0, 1);
        step(0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000);
        step(0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001);
        idle(0, 3);

        random_phase(0, 300);
        random_phase(1, 300);
        random_phase(2, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
